// File: rtl/rs_pkg.sv
// rs_wakeup_buffer shared types and widths.
// Entry record and index/count widths derived from the default depth.
package rs_pkg;

  localparam int RS_DEPTH  = 8;
  localparam int RS_DATA_W = 32;
  localparam int RS_TAG_W  = 4;
  localparam int RS_IDX_W  = $clog2(RS_DEPTH);
  localparam int RS_CNT_W  = $clog2(RS_DEPTH + 1);

  typedef struct packed {
    logic                 valid;
    logic [RS_DATA_W-1:0] data;
    logic [RS_TAG_W-1:0]  rs1_tag;
    logic                 rs1_rdy;
    logic [RS_TAG_W-1:0]  rs2_tag;
    logic                 rs2_rdy;
    logic [RS_TAG_W-1:0]  dst_tag;
  } rs_entry_t;

endpackage

// File: rtl/rs_wakeup_buffer_if.sv
// rs_wakeup_buffer port bundle: dispatch, CDB snoop, issue.
// master drives dispatch/CDB/issue-ready, slave is the buffer.
interface rs_wakeup_buffer_if
  import rs_pkg::*;
#(
  parameter int DATA_W = RS_DATA_W,
  parameter int TAG_W  = RS_TAG_W,
  parameter int IDX_W  = RS_IDX_W,
  parameter int CNT_W  = RS_CNT_W
) ();

  logic              flush_i;
  logic              disp_valid_i;
  logic              disp_ready_o;
  logic [DATA_W-1:0] disp_data_i;
  logic [TAG_W-1:0]  disp_rs1_tag_i;
  logic [TAG_W-1:0]  disp_rs2_tag_i;
  logic              disp_rs1_rdy_i;
  logic              disp_rs2_rdy_i;
  logic [TAG_W-1:0]  disp_dst_tag_i;
  logic              cdb_valid_i;
  logic [TAG_W-1:0]  cdb_tag_i;
  logic              issue_valid_o;
  logic              issue_ready_i;
  logic [DATA_W-1:0] issue_data_o;
  logic [TAG_W-1:0]  issue_dst_tag_o;
  logic [IDX_W-1:0]  issue_idx_o;
  logic [CNT_W-1:0]  occupancy_o;

  modport master (
    output flush_i, disp_valid_i, disp_data_i,
    output disp_rs1_tag_i, disp_rs2_tag_i,
    output disp_rs1_rdy_i, disp_rs2_rdy_i,
    output disp_dst_tag_i, cdb_valid_i, cdb_tag_i,
    output issue_ready_i,
    input  disp_ready_o, issue_valid_o, issue_data_o,
    input  issue_dst_tag_o, issue_idx_o, occupancy_o
  );

  modport slave (
    input  flush_i, disp_valid_i, disp_data_i,
    input  disp_rs1_tag_i, disp_rs2_tag_i,
    input  disp_rs1_rdy_i, disp_rs2_rdy_i,
    input  disp_dst_tag_i, cdb_valid_i, cdb_tag_i,
    input  issue_ready_i,
    output disp_ready_o, issue_valid_o, issue_data_o,
    output issue_dst_tag_o, issue_idx_o, occupancy_o
  );

endinterface

// File: rtl/rs_wakeup_entry.sv
// One reservation-station slot: storage, CDB tag match, dispatch bypass.
// Allocation and issue-free never hit the same slot in one cycle.
module rs_wakeup_entry
  import rs_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  input  logic                 i_alloc,
  input  logic                 i_free,
  input  rs_entry_t            i_disp,
  input  logic                 i_cdb_valid,
  input  logic [RS_TAG_W-1:0]  i_cdb_tag,
  output logic                 o_valid,
  output logic                 o_ready,
  output logic [RS_DATA_W-1:0] o_data,
  output logic [RS_TAG_W-1:0]  o_dst_tag
);

  rs_entry_t r_entry;

  logic w_hit1;
  logic w_hit2;
  logic w_byp1;
  logic w_byp2;

  assign w_hit1 = i_cdb_valid & (i_cdb_tag == r_entry.rs1_tag);
  assign w_hit2 = i_cdb_valid & (i_cdb_tag == r_entry.rs2_tag);
  assign w_byp1 = i_cdb_valid & (i_cdb_tag == i_disp.rs1_tag);
  assign w_byp2 = i_cdb_valid & (i_cdb_tag == i_disp.rs2_tag);

  // slot write, issue-free and operand wakeup
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_entry <= '0;
    end else if (i_flush) begin
      r_entry.valid <= 1'b0;
    end else if (i_alloc) begin
      r_entry         <= i_disp;
      r_entry.valid   <= 1'b1;
      r_entry.rs1_rdy <= i_disp.rs1_rdy | w_byp1;
      r_entry.rs2_rdy <= i_disp.rs2_rdy | w_byp2;
    end else begin
      if (i_free)
        r_entry.valid <= 1'b0;
      if (r_entry.valid && w_hit1)
        r_entry.rs1_rdy <= 1'b1;
      if (r_entry.valid && w_hit2)
        r_entry.rs2_rdy <= 1'b1;
    end
  end

  assign o_valid   = r_entry.valid;
  assign o_ready   = r_entry.valid
                   & r_entry.rs1_rdy
                   & r_entry.rs2_rdy;
  assign o_data    = r_entry.data;
  assign o_dst_tag = r_entry.dst_tag;

endmodule

// File: rtl/rs_wakeup_buffer.sv
// Reservation-station issue buffer with CDB wakeup.
// RS_AGE_PRIO_EN: oldest-ready issue via age matrix (default lowest index).
module rs_wakeup_buffer
  import rs_pkg::*;
#(
  parameter int DEPTH  = RS_DEPTH,
  parameter int DATA_W = RS_DATA_W,
  parameter int TAG_W  = RS_TAG_W
) (
  input logic          clk_i,
  input logic          rst_n_i,
  rs_wakeup_buffer_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  rs_entry_t         w_disp;
  logic [DEPTH-1:0]  w_valid;
  logic [DEPTH-1:0]  w_free;
  logic [DEPTH-1:0]  w_ready;
  logic [DEPTH-1:0]  w_alloc_oh;
  logic [DEPTH-1:0]  w_sel_oh;
  logic [DEPTH-1:0]  w_free_oh;
  logic [DATA_W-1:0] w_data [DEPTH];
  logic [TAG_W-1:0]  w_dst  [DEPTH];
  logic [DATA_W-1:0] w_issue_data;
  logic [TAG_W-1:0]  w_issue_dst;
  logic [IDX_W-1:0]  w_issue_idx;
  logic              w_disp_fire;
  logic              w_issue_fire;
  logic [CNT_W-1:0]  r_occ;

  assign w_disp = '{
    valid:   1'b1,
    data:    bus.disp_data_i,
    rs1_tag: bus.disp_rs1_tag_i,
    rs1_rdy: bus.disp_rs1_rdy_i,
    rs2_tag: bus.disp_rs2_tag_i,
    rs2_rdy: bus.disp_rs2_rdy_i,
    dst_tag: bus.disp_dst_tag_i
  };

  assign w_free = ~w_valid;

  assign bus.disp_ready_o  = rst_n_i & (|w_free);
  assign bus.issue_valid_o = rst_n_i & (|w_ready);

  assign w_disp_fire  = bus.disp_valid_i
                      & bus.disp_ready_o;
  assign w_issue_fire = bus.issue_valid_o
                      & bus.issue_ready_i;

  assign w_free_oh = w_sel_oh & {DEPTH{w_issue_fire}};

  // lowest-index free slot, qualified by the dispatch handshake
  always_comb begin
    w_alloc_oh = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_free[i]) begin
        w_alloc_oh    = '0;
        w_alloc_oh[i] = 1'b1;
      end
    end
    w_alloc_oh = w_alloc_oh & {DEPTH{w_disp_fire}};
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    rs_wakeup_entry u_ent (
      .i_clk       (clk_i),
      .i_rst_n     (rst_n_i),
      .i_flush     (bus.flush_i),
      .i_alloc     (w_alloc_oh[g]),
      .i_free      (w_free_oh[g]),
      .i_disp      (w_disp),
      .i_cdb_valid (bus.cdb_valid_i),
      .i_cdb_tag   (bus.cdb_tag_i),
      .o_valid     (w_valid[g]),
      .o_ready     (w_ready[g]),
      .o_data      (w_data[g]),
      .o_dst_tag   (w_dst[g])
    );
  end

`ifdef RS_AGE_PRIO_EN
  // r_age[i][j]=1: entry j was allocated before entry i
  logic [DEPTH-1:0] r_age [DEPTH];

  // age rows set on allocation, columns cleared on free
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst_n_i || bus.flush_i)
        r_age[i] <= '0;
      else if (w_alloc_oh[i])
        r_age[i] <= w_valid & ~w_free_oh;
      else
        r_age[i] <= r_age[i] & ~w_free_oh;
    end
  end

  // oldest ready entry: ready with no older ready entry
  always_comb begin
    w_sel_oh = '0;
    for (int i = 0; i < DEPTH; i++)
      w_sel_oh[i] = w_ready[i] & ~(|(r_age[i] & w_ready));
  end
`else
  // lowest-index ready entry
  always_comb begin
    w_sel_oh = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_sel_oh    = '0;
        w_sel_oh[i] = 1'b1;
      end
    end
  end
`endif

  // one-hot mux of the selected entry onto the issue port
  always_comb begin
    w_issue_idx  = '0;
    w_issue_data = '0;
    w_issue_dst  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_sel_oh[i]) begin
        w_issue_idx  = w_issue_idx | IDX_W'(i);
        w_issue_data = w_issue_data | w_data[i];
        w_issue_dst  = w_issue_dst | w_dst[i];
      end
    end
  end

  assign bus.issue_idx_o     = rst_n_i ? w_issue_idx  : '0;
  assign bus.issue_data_o    = rst_n_i ? w_issue_data : '0;
  assign bus.issue_dst_tag_o = rst_n_i ? w_issue_dst  : '0;

  // occupancy tracks dispatch and issue; flush wins over both
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || bus.flush_i) begin
      r_occ <= '0;
    end else begin
      unique case ({w_disp_fire, w_issue_fire})
        2'b10:   r_occ <= r_occ + CNT_W'(1);
        2'b01:   r_occ <= r_occ - CNT_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign bus.occupancy_o = r_occ;

endmodule
